// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control encodings, bubble/NOP constants and forward select codes
package pipe_pkg;

    typedef struct packed {
        logic       rd_wren;
        logic [1:0] wbsel;
        logic       mem_wren;
        logic       br_un;
        logic [3:0] alu_op;
        logic [6:2] opcode;
    } pipe_ctrl_t;

    localparam int CTRL_W = $bits(pipe_ctrl_t);

    // A bubble disables every write and decodes as an OP-IMM, so it looks like addi x0,x0,0
    localparam pipe_ctrl_t CTRL_BUBBLE = '{rd_wren: 1'b0, wbsel: 2'b00, mem_wren: 1'b0,
                                           br_un: 1'b0, alu_op: 4'h0, opcode: 5'b00100};

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_regs.sv
// pipe_hazard_regs: PC, IF/ID and ID/EX registers under hazard-unit stall/flush control,
// plus EX operand forwarding and stall/flush event counters
module pipe_hazard_regs
    import pipe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    parameter int              CNT_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall_pc,
    input  logic              i_stall_IF,
    input  logic              i_flush_IF,
    input  logic              i_flush_ID,
    input  logic              i_pc_sel_EX,
    input  logic [XLEN-1:0]   i_alu_data_EX,
    input  logic [1:0]        i_fwd_a,
    input  logic [1:0]        i_fwd_b,
    input  logic [31:0]       i_imem_instr,
    input  logic [CTRL_W-1:0] i_ctrl_ID,
    input  logic [4:0]        i_rs1_addr_ID,
    input  logic [4:0]        i_rs2_addr_ID,
    input  logic [4:0]        i_rd_addr_ID,
    input  logic [XLEN-1:0]   i_rs1_data_ID,
    input  logic [XLEN-1:0]   i_rs2_data_ID,
    input  logic [XLEN-1:0]   i_imm_ID,
    input  logic [XLEN-1:0]   i_alu_data_MEM,
    input  logic [XLEN-1:0]   i_wb_data_WB,
    output logic [XLEN-1:0]   o_pc_IF,
    output logic [XLEN-1:0]   o_pc_ID,
    output logic [31:0]       o_instr_ID,
    output logic              o_valid_ID,
    output logic [XLEN-1:0]   o_pc_EX,
    output logic [CTRL_W-1:0] o_ctrl_EX,
    output logic [XLEN-1:0]   o_imm_EX,
    output logic              o_valid_EX,
    output logic [4:0]        o_rs1_addr_EX,
    output logic [4:0]        o_rs2_addr_EX,
    output logic [4:0]        o_rd_addr_EX,
    output logic [XLEN-1:0]   o_opa_EX,
    output logic [XLEN-1:0]   o_opb_EX,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    logic [XLEN-1:0] rs1_data_EX;
    logic [XLEN-1:0] rs2_data_EX;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) o_pc_IF <= PC_RESET;
        else if (i_pc_sel_EX) o_pc_IF <= i_alu_data_EX;
        else if (!i_stall_pc) o_pc_IF <= o_pc_IF + XLEN'(4);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || i_flush_IF) begin
            o_pc_ID    <= '0;
            o_instr_ID <= NOP_INSTR;
            o_valid_ID <= 1'b0;
        end else if (!i_stall_IF) begin
            o_pc_ID    <= o_pc_IF;
            o_instr_ID <= i_imem_instr;
            o_valid_ID <= 1'b1;
        end
    end

    // Bubbles clear the rs fields too, otherwise a stale address could trigger forwarding
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || i_flush_ID) begin
            o_pc_EX       <= '0;
            o_ctrl_EX     <= CTRL_BUBBLE;
            o_imm_EX      <= '0;
            o_valid_EX    <= 1'b0;
            o_rs1_addr_EX <= '0;
            o_rs2_addr_EX <= '0;
            o_rd_addr_EX  <= '0;
            rs1_data_EX   <= '0;
            rs2_data_EX   <= '0;
        end else begin
            o_pc_EX       <= o_pc_ID;
            o_ctrl_EX     <= i_ctrl_ID;
            o_imm_EX      <= i_imm_ID;
            o_valid_EX    <= o_valid_ID;
            o_rs1_addr_EX <= i_rs1_addr_ID;
            o_rs2_addr_EX <= i_rs2_addr_ID;
            o_rd_addr_EX  <= i_rd_addr_ID;
            rs1_data_EX   <= i_rs1_data_ID;
            rs2_data_EX   <= i_rs2_data_ID;
        end
    end

    always_comb begin
        o_opa_EX = (i_fwd_a == FWD_MEM) ? i_alu_data_MEM : (i_fwd_a == FWD_WB) ? i_wb_data_WB : rs1_data_EX;
        o_opb_EX = (i_fwd_b == FWD_MEM) ? i_alu_data_MEM : (i_fwd_b == FWD_WB) ? i_wb_data_WB : rs2_data_EX;
    end

    // A redirect cancels the stall, so it is not counted as one
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(i_clk), .rst(i_reset), .inc(i_stall_pc && !i_pc_sel_EX), .cnt(o_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(i_clk), .rst(i_reset), .inc(i_flush_IF || i_flush_ID), .cnt(o_flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_regs.sv
// tb_pipe_hazard_regs: directed vectors for pipeline register control, forwarding and counters
module tb_pipe_hazard_regs;
    import pipe_pkg::*;

    localparam int XLEN = 32;
    localparam int CNT_W = 4;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_stall_pc, i_stall_IF, i_flush_IF, i_flush_ID, i_pc_sel_EX;
    logic [XLEN-1:0]   i_alu_data_EX;
    logic [1:0]        i_fwd_a, i_fwd_b;
    logic [31:0]       i_imem_instr;
    logic [CTRL_W-1:0] i_ctrl_ID;
    logic [4:0]        i_rs1_addr_ID, i_rs2_addr_ID, i_rd_addr_ID;
    logic [XLEN-1:0]   i_rs1_data_ID, i_rs2_data_ID, i_imm_ID;
    logic [XLEN-1:0]   i_alu_data_MEM, i_wb_data_WB;
    logic [XLEN-1:0]   o_pc_IF, o_pc_ID, o_pc_EX, o_imm_EX, o_opa_EX, o_opb_EX;
    logic [31:0]       o_instr_ID;
    logic              o_valid_ID, o_valid_EX;
    logic [CTRL_W-1:0] o_ctrl_EX;
    logic [4:0]        o_rs1_addr_EX, o_rs2_addr_EX, o_rd_addr_EX;
    logic [CNT_W-1:0]  o_stall_cnt, o_flush_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] ea;
        logic [31:0] eb;
    } fwd_vec_t;

    fwd_vec_t vec [4];

    pipe_hazard_regs #(.XLEN(XLEN), .PC_RESET(32'h0), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_stall_pc(i_stall_pc), .i_stall_IF(i_stall_IF),
        .i_flush_IF(i_flush_IF), .i_flush_ID(i_flush_ID),
        .i_pc_sel_EX(i_pc_sel_EX), .i_alu_data_EX(i_alu_data_EX),
        .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b), .i_imem_instr(i_imem_instr),
        .i_ctrl_ID(i_ctrl_ID), .i_rs1_addr_ID(i_rs1_addr_ID),
        .i_rs2_addr_ID(i_rs2_addr_ID), .i_rd_addr_ID(i_rd_addr_ID),
        .i_rs1_data_ID(i_rs1_data_ID), .i_rs2_data_ID(i_rs2_data_ID),
        .i_imm_ID(i_imm_ID), .i_alu_data_MEM(i_alu_data_MEM), .i_wb_data_WB(i_wb_data_WB),
        .o_pc_IF(o_pc_IF), .o_pc_ID(o_pc_ID), .o_instr_ID(o_instr_ID), .o_valid_ID(o_valid_ID),
        .o_pc_EX(o_pc_EX), .o_ctrl_EX(o_ctrl_EX), .o_imm_EX(o_imm_EX), .o_valid_EX(o_valid_EX),
        .o_rs1_addr_EX(o_rs1_addr_EX), .o_rs2_addr_EX(o_rs2_addr_EX), .o_rd_addr_EX(o_rd_addr_EX),
        .o_opa_EX(o_opa_EX), .o_opb_EX(o_opb_EX),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_stall_pc = 0; i_stall_IF = 0; i_flush_IF = 0; i_flush_ID = 0; i_pc_sel_EX = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc_IF"}, o_pc_IF, 32'h0);
        check({tag, " instr_ID"}, o_instr_ID, NOP_INSTR);
        check({tag, " valid_ID"}, 32'(o_valid_ID), 32'h0);
        check({tag, " ctrl_EX"}, 32'(o_ctrl_EX), 32'(CTRL_BUBBLE));
        check({tag, " valid_EX"}, 32'(o_valid_EX), 32'h0);
        check({tag, " stall_cnt"}, 32'(o_stall_cnt), 32'h0);
        check({tag, " flush_cnt"}, 32'(o_flush_cnt), 32'h0);
    endtask

    initial begin
        vec[0] = '{fa: 2'b00, fb: 2'b00, ea: 32'd5, eb: 32'd6};
        vec[1] = '{fa: 2'b10, fb: 2'b01, ea: 32'd7, eb: 32'd9};
        vec[2] = '{fa: 2'b01, fb: 2'b10, ea: 32'd9, eb: 32'd7};
        vec[3] = '{fa: 2'b11, fb: 2'b11, ea: 32'd5, eb: 32'd6};

        i_reset = 1; idle();
        i_alu_data_EX = '0; i_fwd_a = 0; i_fwd_b = 0; i_imem_instr = 32'h0050_0093;
        i_ctrl_ID = 14'h3FFF; i_rs1_addr_ID = 0; i_rs2_addr_ID = 0; i_rd_addr_ID = 5'd5;
        i_rs1_data_ID = '0; i_rs2_data_ID = '0; i_imm_ID = '0;
        i_alu_data_MEM = 32'd7; i_wb_data_WB = 32'd9;
        #2;
        check_reset_state("reset");
        @(negedge i_clk); @(negedge i_clk);
        i_reset = 0;

        for (int k = 1; k <= 4; k++) begin
            tick();
            check("run pc_IF", o_pc_IF, 32'(4 * k));
            check("run valid_ID", 32'(o_valid_ID), 32'h1);
        end
        check("run pc_ID", o_pc_ID, 32'hC);
        check("run instr_ID", o_instr_ID, 32'h0050_0093);
        check("run stall_cnt", 32'(o_stall_cnt), 32'h0);

        // load-use stall at PC 0x10
        i_stall_pc = 1; i_stall_IF = 1; i_flush_ID = 1;
        i_imem_instr = 32'hDEAD_BEEF;
        tick();
        check("stall pc_IF", o_pc_IF, 32'h10);
        check("stall pc_ID", o_pc_ID, 32'hC);
        check("stall instr_ID", o_instr_ID, 32'h0050_0093);
        check("stall ctrl_EX", 32'(o_ctrl_EX), 32'(CTRL_BUBBLE));
        check("stall valid_EX", 32'(o_valid_EX), 32'h0);
        check("stall rd_EX", 32'(o_rd_addr_EX), 32'h0);
        check("stall stall_cnt", 32'(o_stall_cnt), 32'h1);
        check("stall flush_cnt", 32'(o_flush_cnt), 32'h1);

        // redirect with concurrent stall/flush
        i_pc_sel_EX = 1; i_alu_data_EX = 32'h200; i_flush_IF = 1;
        tick();
        check("redir pc_IF", o_pc_IF, 32'h200);
        check("redir instr_ID", o_instr_ID, NOP_INSTR);
        check("redir valid_ID", 32'(o_valid_ID), 32'h0);
        check("redir stall_cnt", 32'(o_stall_cnt), 32'h1);
        check("redir flush_cnt", 32'(o_flush_cnt), 32'h2);

        idle();
        i_ctrl_ID = 14'h1ABC; i_rs1_addr_ID = 5'd1; i_rs2_addr_ID = 5'd2; i_rd_addr_ID = 5'd3;
        i_rs1_data_ID = 32'd5; i_rs2_data_ID = 32'd6; i_imm_ID = 32'h77;
        tick();
        check("cap pc_IF", o_pc_IF, 32'h204);
        check("cap pc_ID", o_pc_ID, 32'h200);
        check("cap valid_ID", 32'(o_valid_ID), 32'h1);
        check("cap ctrl_EX", 32'(o_ctrl_EX), 32'h1ABC);
        check("cap valid_EX", 32'(o_valid_EX), 32'h0);
        check("cap rs1_EX", 32'(o_rs1_addr_EX), 32'h1);
        check("cap rs2_EX", 32'(o_rs2_addr_EX), 32'h2);
        check("cap rd_EX", 32'(o_rd_addr_EX), 32'h3);
        check("cap imm_EX", o_imm_EX, 32'h77);

        // freeze ID/EX data by flushing nothing but keeping ID inputs, then sweep forward selects
        @(negedge i_clk);
        for (int i = 0; i < 4; i++) begin
            i_fwd_a = vec[i].fa; i_fwd_b = vec[i].fb;
            #1;
            check($sformatf("fwd opa sel=%b", vec[i].fa), o_opa_EX, vec[i].ea);
            check($sformatf("fwd opb sel=%b", vec[i].fb), o_opb_EX, vec[i].eb);
        end
        i_fwd_a = 0; i_fwd_b = 0;

        i_pc_sel_EX = 1; i_alu_data_EX = 32'hFFFF_FFFC;
        tick();
        check("wrap pc load", o_pc_IF, 32'hFFFF_FFFC);
        idle();
        tick();
        check("wrap pc", o_pc_IF, 32'h0);

        // stall count goes 1 -> 15 in 14 edges, then must stick
        i_stall_pc = 1; i_stall_IF = 1;
        repeat (14) tick();
        check("sat reach", 32'(o_stall_cnt), 32'hF);
        repeat (3) tick();
        check("sat hold", 32'(o_stall_cnt), 32'hF);
        check("sat pc hold", o_pc_IF, 32'h0);

        // mid-cycle reset with a redirect pending
        i_stall_pc = 0; i_flush_ID = 1; i_pc_sel_EX = 1; i_alu_data_EX = 32'h400;
        @(posedge i_clk); #3;
        i_reset = 1;
        #1;
        check_reset_state("async");
        tick();
        check("async hold pc_IF", o_pc_IF, 32'h0);
        @(negedge i_clk);
        idle();
        i_reset = 0;
        tick();
        check("post pc_IF", o_pc_IF, 32'h4);
        check("post valid_ID", 32'(o_valid_ID), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_regs.md
Name: pipe_hazard_regs

Overview:
- Consumer end of the hazard/forwarding control interface: owns PC, IF/ID and ID/EX pipeline registers and applies the stall, flush and forward controls to them.
- Sits between the fetch/decode/execute datapath and the hazard unit. Also performs EX operand forwarding selection.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
XLEN, 32, datapath and PC width
PC_RESET, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of each event counter

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_stall_pc  in  1  hold PC
i_stall_IF  in  1  hold IF/ID register
i_flush_IF  in  1  load NOP bubble into IF/ID
i_flush_ID  in  1  load bubble into ID/EX
i_pc_sel_EX  in  1  redirect: next PC = i_alu_data_EX
i_alu_data_EX  in  XLEN  branch/jump target
i_fwd_a, i_fwd_b  in  2  operand select; 00 regfile, 10 MEM, 01 WB, 11 regfile
i_imem_instr  in  32  instruction at o_pc_IF
i_ctrl_ID  in  CTRL_W  packed decoded control (pipe_ctrl_t)
i_rs1_addr_ID, i_rs2_addr_ID, i_rd_addr_ID  in  5  decoded register addresses
i_rs1_data_ID, i_rs2_data_ID, i_imm_ID  in  XLEN  regfile read data, immediate
i_alu_data_MEM  in  XLEN  MEM-stage forward source
i_wb_data_WB  in  XLEN  WB-stage forward source
o_pc_IF  out  XLEN  fetch PC
o_pc_ID, o_instr_ID, o_valid_ID  out  XLEN/32/1  IF/ID contents
o_pc_EX, o_ctrl_EX, o_imm_EX, o_valid_EX  out  XLEN/CTRL_W/XLEN/1  ID/EX contents
o_rs1_addr_EX, o_rs2_addr_EX, o_rd_addr_EX  out  5  fed back to hazard unit
o_opa_EX, o_opb_EX  out  XLEN  forwarded operands
o_stall_cnt, o_flush_cnt  out  CNT_W  event counters

Behaviour:
- Reset (async, immediate):
  - PC = PC_RESET.
  - IF/ID: instr = 32'h0000_0013, pc = 0, valid = 0.
  - ID/EX: ctrl = CTRL_BUBBLE, all addresses/data = 0, valid = 0.
  - Both counters = 0.
- PC update, per edge, in priority order:
  1. i_pc_sel_EX -> i_alu_data_EX (redirect overrides stall).
  2. i_stall_pc -> hold.
  3. Otherwise PC + 4, wrapping modulo 2^XLEN.
- IF/ID update, per edge, in priority order:
  1. i_flush_IF -> instr NOP, valid 0 (flush beats stall).
  2. i_stall_IF -> hold.
  3. Otherwise capture {o_pc_IF, i_imem_instr}, valid 1.
- ID/EX update, per edge:
  - i_flush_ID -> bubble: ctrl = CTRL_BUBBLE, rd = 0, valid 0. Rs addresses and data are zeroed so no false forwarding occurs.
  - Otherwise capture all ID inputs; valid = o_valid_ID.
  - ID/EX is never held: a load-use stall is realised as flush_ID plus IF/PC hold.
- Forwarding mux:
  - Combinational, zero latency: o_opa_EX from i_fwd_a, o_opb_EX from i_fwd_b.
  - Codes 00 and 11 select the ID/EX register data.
- Counters:
  - o_stall_cnt increments on each edge with i_stall_pc = 1 and i_pc_sel_EX = 0.
  - o_flush_cnt increments on each edge with i_flush_IF | i_flush_ID.
  - Both saturate at all-ones and do not wrap.
- Simultaneous stall and flush: the load-use bubble and a redirect in the same cycle resolve per the priorities above. The stall count is not taken.
- Reset asserted mid-stall or mid-flush: all state returns to reset values; no pending redirect survives.

Decomposition:
- Package pipe_pkg:
  - pipe_ctrl_t packed struct: rd_wren, wbsel[1:0], mem_wren, br_un, alu_op[3:0], opcode[6:2]; CTRL_W = $bits.
  - CTRL_BUBBLE constant: all enables 0, opcode 5'b00100.
  - NOP_INSTR = 32'h0000_0013.
  - fwd_sel_e enum: FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10.
- One sub-module, sat_counter (parameter CNT_W, inc input, async reset), instantiated twice.

Test Plan:
- Reset release, no stall/flush, 4 cycles -> o_pc_IF 0,4,8,12; o_valid_ID 1 from cycle 2; counters 0.
- i_stall_pc = i_stall_IF = i_flush_ID = 1 for 1 cycle at PC 0x10 -> PC holds 0x10; IF/ID holds; o_ctrl_EX = CTRL_BUBBLE, o_valid_EX 0; o_stall_cnt 1, o_flush_cnt 1.
- i_pc_sel_EX = 1, i_alu_data_EX = 0x200, flush_IF = flush_ID = 1, with i_stall_pc = 1 -> next PC 0x200; IF/ID instr 0x00000013, valid 0; o_stall_cnt unchanged.
- rs1_data_EX 5, i_alu_data_MEM 7, i_wb_data_WB 9; i_fwd_a 00/10/01/11 -> o_opa_EX 5/7/9/5 in the same cycle. Repeat for b.
- PC at 0xFFFF_FFFC, no stall -> PC wraps to 0x0000_0000.
- Force counter to all-ones and stall again -> o_stall_cnt stays all-ones. Assert i_reset mid-cycle -> outputs reach reset values before the next edge.
